cla_add_scheduler: RTL and testbench

- Shares one external 16-bit carry-lookahead adder among NREQ requesters.
- Round-robin arbiter picks one request per transaction.
- Sequencer runs a multi-word add/subtract (16*NWORDS bits) through the adder, one 16-bit word per cycle, low word first, with the carry held in a register between words.
- Returns the result on a valid/ready response channel. Sits between client datapaths and the shared adder instance.

---
 rtl/cla_add_scheduler.sv | 156 +++++++++++++++
 tb/tb_cla_add_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cla_add_scheduler.sv
// rtl/cla_add_scheduler.sv - round-robin scheduler sharing one 16-bit CLA adder for multi-word add/sub
// Optional adder self-check enabled by defining CLA_SCHED_CHECK_EN.
module cla_add_scheduler #(
    parameter int NREQ   = 2,
    parameter int NWORDS = 2,
    parameter int IDW    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NREQ-1:0]             req_valid,
    output logic [NREQ-1:0]             req_ready,
    input  logic [NREQ*16*NWORDS-1:0]   req_a,
    input  logic [NREQ*16*NWORDS-1:0]   req_b,
    input  logic [NREQ-1:0]             req_sub,
    output logic [15:0]                 adder_a,
    output logic [15:0]                 adder_b,
    output logic                        adder_cin,
    input  logic [15:0]                 adder_sum,
    input  logic                        adder_cout,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [IDW-1:0]              rsp_id,
    output logic [16*NWORDS-1:0]        rsp_sum,
    output logic                        rsp_cout,
    output logic                        rsp_ovf,
    output logic                        busy,
    output logic                        chk_err
);
    localparam int W  = 16 * NWORDS;
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int KW = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t          state;
    logic [PW-1:0]   rr_ptr;
    logic [KW-1:0]   widx;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    b_reg;
    logic [W-1:0]    res_reg;
    logic            sub_reg;
    logic            carry_reg;
    logic [IDW-1:0]  id_reg;

    logic            found;
    logic [PW-1:0]   win;
    logic [PW:0]     rot;

    // Scan requesters starting at the RR pointer, wrapping modulo NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        rot   = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot = {1'b0, rr_ptr} + (PW+1)'(i);
            if (rot >= (PW+1)'(NREQ)) begin
                rot = rot - (PW+1)'(NREQ);
            end
            if (!found && req_valid[rot[PW-1:0]]) begin
                found = 1'b1;
                win   = rot[PW-1:0];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && found) begin
            req_ready[win] = 1'b1;
        end
    end

    always_comb begin
        adder_a   = '0;
        adder_b   = '0;
        adder_cin = 1'b0;
        if (state == EXEC) begin
            adder_a   = a_reg[widx*16 +: 16];
            adder_b   = b_reg[widx*16 +: 16];
            adder_cin = (widx == '0) ? sub_reg : carry_reg;
        end
    end

    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign rsp_sum   = res_reg;
    assign rsp_cout  = carry_reg;
    assign rsp_id    = id_reg;
    // b_reg already holds the inverted operand for subtract, so one rule covers both.
    assign rsp_ovf   = (a_reg[W-1] == b_reg[W-1]) && (res_reg[W-1] != a_reg[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            widx      <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            res_reg   <= '0;
            sub_reg   <= 1'b0;
            carry_reg <= 1'b0;
            id_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        a_reg   <= req_a[win*W +: W];
                        b_reg   <= req_sub[win] ? ~req_b[win*W +: W] : req_b[win*W +: W];
                        sub_reg <= req_sub[win];
                        id_reg  <= IDW'(win);
                        rr_ptr  <= (win == PW'(NREQ-1)) ? '0 : win + 1'b1;
                        widx    <= '0;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    res_reg[widx*16 +: 16] <= adder_sum;
                    carry_reg              <= adder_cout;
                    if (widx == KW'(NWORDS-1)) begin
                        state <= RESP;
                    end else begin
                        widx <= widx + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CLA_SCHED_CHECK_EN
    logic [16:0] model_sum;
    logic        mismatch;
    logic        chk_sticky;

    assign model_sum = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};
    assign mismatch  = (state == EXEC) && (model_sum != {adder_cout, adder_sum});
    // Flag visible in the offending cycle, then held until reset.
    assign chk_err   = chk_sticky | mismatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_sticky <= 1'b0;
        end else if (mismatch) begin
            chk_sticky <= 1'b1;
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_cla_add_scheduler.sv
// tb/tb_cla_add_scheduler.sv - self-checking bench for cla_add_scheduler (NREQ=2, NWORDS=2)
module tb_cla_add_scheduler;
    localparam int NREQ = 2, NWORDS = 2, IDW = 1, W = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid, req_ready, req_sub;
    logic [NREQ*W-1:0]    req_a, req_b;
    logic [15:0]          adder_a, adder_b, adder_sum;
    logic                 adder_cin, adder_cout;
    logic                 rsp_valid, rsp_ready, rsp_cout, rsp_ovf, busy, chk_err;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_sum;
    logic                 fault;
    logic [16:0]          add_full;

    int total = 0;
    int bad   = 0;

    cla_add_scheduler #(.NREQ(NREQ), .NWORDS(NWORDS), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_sub(req_sub),
        .adder_a(adder_a), .adder_b(adder_b), .adder_cin(adder_cin),
        .adder_sum(adder_sum), .adder_cout(adder_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_ovf(rsp_ovf),
        .busy(busy), .chk_err(chk_err)
    );

    // Shared adder; fault forces sum bit 15 low.
    assign add_full   = {1'b0, adder_a} + {1'b0, adder_b} + {16'd0, adder_cin};
    assign adder_sum  = fault ? (add_full[15:0] & 16'h7FFF) : add_full[15:0];
    assign adder_cout = add_full[16];

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain 32-bit arithmetic, returns {ovf, cout, sum}.
    function automatic logic [33:0] ref_add(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [32:0] full;
        logic [31:0] s;
        logic        c, o;
        if (sub) begin
            s = a - b;
            c = (a >= b);
            o = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            s = full[31:0];
            c = full[32];
            o = (a[31] == b[31]) && (s[31] != a[31]);
        end
        return {o, c, s};
    endfunction

    function automatic logic low_carry(input logic [31:0] a, input logic [31:0] b, input logic sub);
        if (sub) return (a[15:0] >= b[15:0]);
        return ((32'(a[15:0]) + 32'(b[15:0])) > 32'hFFFF);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic do_txn(input int id, input logic [31:0] a, input logic [31:0] b, input logic sub,
                          input logic [31:0] es, input logic ec, input logic eo);
        logic [1:0]  onehot;
        logic [15:0] bl, bh;
        onehot = '0;
        onehot[id] = 1'b1;
        bl = sub ? ~b[15:0]  : b[15:0];
        bh = sub ? ~b[31:16] : b[31:16];
        @(negedge clk);
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_sub = 2'($urandom);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_sub[id] = sub;
        req_valid = onehot;
        rsp_ready = 1'b0;
        #1;
        for (int n = 0; n < 20 && req_ready !== onehot; n++) begin
            @(negedge clk);
            #1;
        end
        chk("grant", 64'(req_ready), 64'(onehot));
        @(negedge clk);
        req_valid = '0;
        chk("w0_adder_a", 64'(adder_a), 64'(a[15:0]));
        chk("w0_adder_b", 64'(adder_b), 64'(bl));
        chk("w0_adder_cin", 64'(adder_cin), 64'(sub));
        chk("w0_busy", 64'(busy), 64'd1);
        chk("w0_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("w1_adder_a", 64'(adder_a), 64'(a[31:16]));
        chk("w1_adder_b", 64'(adder_b), 64'(bh));
        chk("w1_adder_cin", 64'(adder_cin), 64'(low_carry(a, b, sub)));
        chk("w1_rsp_valid", 64'(rsp_valid), 64'd0);
        @(negedge clk);
        chk("latency_rsp_valid", 64'(rsp_valid), 64'd1);
        for (int n = 0; n < 10 && rsp_valid !== 1'b1; n++) @(negedge clk);
        chk("rsp_sum", 64'(rsp_sum), 64'(es));
        chk("rsp_cout", 64'(rsp_cout), 64'(ec));
        chk("rsp_ovf", 64'(rsp_ovf), 64'(eo));
        chk("rsp_id", 64'(rsp_id), 64'(id));
        chk("resp_adder_idle", 64'({adder_a, adder_b, adder_cin}), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("post_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        vec_t        tbl[6];
        logic [33:0] r;
        logic [31:0] ra, rb;
        logic        rs;
        int          rid;
        int          ng;
        int          gid[4];
        int          gcyc[4];
        int          seen;

        tbl[0] = '{0, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tbl[1] = '{1, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[2] = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[3] = '{1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[4] = '{0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[5] = '{1, 32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};

        fault = 1'b0; rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
        req_a = '0; req_b = '0; req_sub = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_fields", 64'({rsp_sum, rsp_cout, rsp_ovf, rsp_id}), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_adder", 64'({adder_a, adder_b, adder_cin}), 64'd0);
        chk("rst_chk_err", 64'(chk_err), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        req_valid = 2'b10; #1;
        chk("prio_only1", 64'(req_ready), 64'd2);
        req_valid = 2'b11; #1;
        chk("prio_both", 64'(req_ready), 64'd1);
        req_valid = 2'b00; #1;
        chk("prio_none", 64'(req_ready), 64'd0);

        for (int i = 0; i < 6; i++) begin
            do_txn(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].s, tbl[i].c, tbl[i].o);
        end

        for (int i = 0; i < 40; i++) begin
            rid = int'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = (i % 5 == 0) ? ~ra : $urandom;
            rs  = 1'($urandom);
            r   = ref_add(ra, rb, rs);
            do_txn(rid, ra, rb, rs, r[31:0], r[32], r[33]);
        end

        // Arbitration with both requesters held, then backpressure
        do_reset();
        @(negedge clk);
        req_a = {32'h7FFF0001, 32'h11112222};
        req_b = {32'h00010FFF, 32'h01010101};
        req_sub = 2'b00;
        req_valid = 2'b11;
        rsp_ready = 1'b1;
        ng = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req_ready != 2'b00 && ng < 4) begin
                gid[ng]  = req_ready[1] ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            if (ng == 4) break;
            @(negedge clk);
        end
        rsp_ready = 1'b0;
        chk("arb_grant_count", 64'(ng), 64'd4);
        if (ng == 4) begin
            for (int g = 0; g < 4; g++) chk("arb_order", 64'(gid[g]), 64'(g % 2));
            for (int g = 1; g < 4; g++) chk("arb_spacing", 64'(gcyc[g] - gcyc[g-1]), 64'd4);
        end
        for (int n = 0; n < 10 && rsp_valid !== 1'b1; n++) @(negedge clk);
        r = ref_add(32'h7FFF0001, 32'h00010FFF, 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_sum", 64'(rsp_sum), 64'(r[31:0]));
            chk("bp_rsp_id", 64'(rsp_id), 64'd1);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = 2'b00;
        rsp_ready = 1'b0;
        chk("bp_release", 64'(rsp_valid), 64'd0);

        // Reset during EXEC drops the transaction and the RR pointer
        @(negedge clk);
        req_a[31:0] = 32'h12345678; req_b[31:0] = 32'h1; req_sub = 2'b00;
        req_valid = 2'b01;
        #1;
        for (int n = 0; n < 10 && req_ready !== 2'b01; n++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        req_valid = 2'b00;
        chk("midexec_busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("midexec_busy_rst", 64'(busy), 64'd0);
        chk("midexec_adder_rst", 64'({adder_a, adder_b, adder_cin}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            if (rsp_valid === 1'b1) seen++;
            @(negedge clk);
        end
        chk("midexec_no_rsp", 64'(seen), 64'd0);
        req_valid = 2'b11; #1;
        chk("midexec_rr_reset", 64'(req_ready), 64'd1);
        req_valid = 2'b00;
        do_txn(0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0);

`ifdef CLA_SCHED_CHECK_EN
        fault = 1'b1;
        @(negedge clk);
        req_a[31:0] = 32'h00008000; req_b[31:0] = 32'h0; req_sub = 2'b00;
        req_valid = 2'b01;
        #1;
        for (int n = 0; n < 10 && req_ready !== 2'b01; n++) begin
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        req_valid = 2'b00;
        chk("chk_err_first_exec", 64'(chk_err), 64'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("chk_err_sticky", 64'(chk_err), 64'd1);
        end
        rsp_ready = 1'b0;
        fault = 1'b0;
        do_reset();
        chk("chk_err_cleared", 64'(chk_err), 64'd0);
`else
        chk("chk_err_tied", 64'(chk_err), 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
